// File: rtl/trig_hyst_gen.sv
// trig_hyst_gen
// Hysteresis trigger generator for the scope capture stage. A signed sample
// stream is compared against an excitation and a relaxation threshold. A
// trigger needs a relax-then-excite sequence. After detection the pulse is
// delayed by a programmable count, and a holdoff window follows it.
//
// Ports
//   adc_clk_i        sole clock (ADC domain)
//   adc_rst_i        asynchronous, active-high reset
//   adc_dat_i        signed sample, new value every cycle
//   enable_i         detection enable (level)
//   thresh_excite_i  signed excitation threshold
//   thresh_relax_i   signed relaxation threshold
//   delay_i          cycles from detection to pulse (sampled on DELAY entry)
//   holdoff_i        dead cycles after a pulse (sampled on HOLDOFF entry)
//   count_clr_i      one-cycle pulse, clears trig_count_o
//   trig_o           registered one-cycle trigger pulse
//   armed_o          registered, high while in ARMED
//   trig_count_o     number of pulses emitted, wraps
//   trig_age_o       cycles since the last pulse, saturating; all ones = never
module trig_hyst_gen #(
    parameter int W = 14
) (
    input  logic         adc_clk_i,
    input  logic         adc_rst_i,
    input  logic [W-1:0] adc_dat_i,
    input  logic         enable_i,
    input  logic [W-1:0] thresh_excite_i,
    input  logic [W-1:0] thresh_relax_i,
    input  logic [31:0]  delay_i,
    input  logic [31:0]  holdoff_i,
    input  logic         count_clr_i,
    output logic         trig_o,
    output logic         armed_o,
    output logic [31:0]  trig_count_o,
    output logic [31:0]  trig_age_o
);

    // POST_PULSE is the cycle in which trig_o is high. The holdoff decision is
    // taken there, so a pulse never overlaps the holdoff window.
    typedef enum logic [2:0] {
        WAIT_RELAX = 3'd0,
        ARMED      = 3'd1,
        DELAY      = 3'd2,
        POST_PULSE = 3'd3,
        HOLDOFF    = 3'd4
    } state_t;

    state_t              state_r;
    logic [31:0]         cnt_r;
    logic                trig_r;
    logic                armed_r;
    logic [31:0]         trig_count_r;
    logic [31:0]         trig_age_r;
    logic signed [W-1:0] s_q_r;

    logic excite_hit_s;
    logic relax_hit_s;
    logic degenerate_s;
    logic fire_s;

    // Threshold mode and excite/relax conditions from the live thresholds.
    always_comb begin
        excite_hit_s = 1'b0;
        relax_hit_s  = 1'b0;
        degenerate_s = 1'b0;
        if ($signed(thresh_excite_i) > $signed(thresh_relax_i)) begin
            excite_hit_s = (s_q_r >= $signed(thresh_excite_i));
            relax_hit_s  = (s_q_r <= $signed(thresh_relax_i));
        end else if ($signed(thresh_excite_i) < $signed(thresh_relax_i)) begin
            excite_hit_s = (s_q_r <= $signed(thresh_excite_i));
            relax_hit_s  = (s_q_r >= $signed(thresh_relax_i));
        end else begin
            degenerate_s = 1'b1;
        end
    end

    // A pulse is emitted on the edge that moves the FSM into POST_PULSE.
    always_comb begin
        fire_s = 1'b0;
        if (enable_i && !degenerate_s) begin
            case (state_r)
                ARMED:   fire_s = excite_hit_s && (delay_i == 32'd0);
                DELAY:   fire_s = (cnt_r == 32'd0);
                default: fire_s = 1'b0;
            endcase
        end else begin
            fire_s = 1'b0;
        end
    end

    // Input register, trigger FSM and its registered outputs.
    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            s_q_r   <= '0;
            state_r <= WAIT_RELAX;
            cnt_r   <= 32'd0;
            trig_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            s_q_r  <= $signed(adc_dat_i);
            trig_r <= fire_s;
            if (!enable_i || degenerate_s) begin
                // Abort everything, including a pending delayed trigger.
                state_r <= WAIT_RELAX;
                cnt_r   <= 32'd0;
                armed_r <= 1'b0;
            end else begin
                case (state_r)
                    WAIT_RELAX: begin
                        if (relax_hit_s) begin
                            state_r <= ARMED;
                            armed_r <= 1'b1;
                        end else begin
                            state_r <= WAIT_RELAX;
                            armed_r <= 1'b0;
                        end
                    end
                    ARMED: begin
                        if (excite_hit_s) begin
                            armed_r <= 1'b0;
                            if (delay_i == 32'd0) begin
                                state_r <= POST_PULSE;
                            end else begin
                                state_r <= DELAY;
                                cnt_r   <= delay_i - 32'd1;
                            end
                        end else begin
                            state_r <= ARMED;
                            armed_r <= 1'b1;
                        end
                    end
                    DELAY: begin
                        armed_r <= 1'b0;
                        if (cnt_r == 32'd0) begin
                            state_r <= POST_PULSE;
                        end else begin
                            cnt_r <= cnt_r - 32'd1;
                        end
                    end
                    POST_PULSE: begin
                        armed_r <= 1'b0;
                        if (holdoff_i == 32'd0) begin
                            state_r <= WAIT_RELAX;
                        end else begin
                            state_r <= HOLDOFF;
                            cnt_r   <= holdoff_i - 32'd1;
                        end
                    end
                    HOLDOFF: begin
                        armed_r <= 1'b0;
                        if (cnt_r == 32'd0) begin
                            state_r <= WAIT_RELAX;
                        end else begin
                            cnt_r <= cnt_r - 32'd1;
                        end
                    end
                    default: begin
                        state_r <= WAIT_RELAX;
                        cnt_r   <= 32'd0;
                        armed_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Software-visible trigger count and time since the last pulse.
    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            trig_count_r <= 32'd0;
            trig_age_r   <= 32'hFFFF_FFFF;
        end else begin
            if (fire_s) begin
                trig_count_r <= count_clr_i ? 32'd1 : trig_count_r + 32'd1;
            end else if (count_clr_i) begin
                trig_count_r <= 32'd0;
            end else begin
                trig_count_r <= trig_count_r;
            end
            if (fire_s) begin
                trig_age_r <= 32'd0;
            end else if (trig_age_r != 32'hFFFF_FFFF) begin
                trig_age_r <= trig_age_r + 32'd1;
            end else begin
                trig_age_r <= trig_age_r;
            end
        end
    end

    assign trig_o       = trig_r;
    assign armed_o      = armed_r;
    assign trig_count_o = trig_count_r;
    assign trig_age_o   = trig_age_r;

endmodule

// File: doc/trig_hyst_gen.md
# trig_hyst_gen

Hysteresis trigger generator feeding the scope capture stage. It watches one signed sample stream (fast ADC channel B for the radar trigger, or an XADC channel for ACP/ARP) and emits a single-cycle trigger pulse. The trigger is debounced with separate excitation and relaxation thresholds, then delayed and held off by programmable counts. Three instances drive the scope's `radar_trig_i`, `acp_trig_i` and `arp_trig_i`. Each instance also keeps a trigger count and a time-since-last-trigger counter for software readout.

## Interface
- `W`, 14: sample width, two's complement.
- `adc_clk_i` in 1: sole clock, ADC domain.
- `adc_rst_i` in 1: reset, asynchronous, active-high.
- `adc_dat_i` in W: signed sample, new value every cycle.
- `enable_i` in 1: detection enable, level.
- `thresh_excite_i` in W: signed excitation threshold.
- `thresh_relax_i` in W: signed relaxation threshold.
- `delay_i` in 32: cycles from detection to pulse.
- `holdoff_i` in 32: dead cycles after a pulse.
- `count_clr_i` in 1: one-cycle pulse, clears `trig_count_o`.
- `trig_o` out 1: one-cycle trigger pulse.
- `armed_o` out 1: high in state ARMED.
- `trig_count_o` out 32: number of pulses emitted, wraps.
- `trig_age_o` out 32: cycles since the last pulse, saturating.

## Operation
- Input stage: `adc_dat_i` is registered into `s_q` every cycle. All comparisons use `s_q`, are signed, and are W bits wide.
- Mode is evaluated every cycle from the live thresholds:
  - excite > relax: rising mode. Excite condition `s_q >= excite`; relax condition `s_q <= relax`.
  - excite < relax: falling mode. Excite condition `s_q <= excite`; relax condition `s_q >= relax`.
  - excite == relax: no triggers. The FSM is forced to WAIT_RELAX.
- FSM states are WAIT_RELAX, ARMED, DELAY and HOLDOFF. Reset state is WAIT_RELAX.
- WAIT_RELAX: on the relax condition, go to ARMED.
- ARMED: on the excite condition:
  - if `delay_i==0`: pulse `trig_o`, then go to the post-pulse state.
  - else: latch `cnt = delay_i - 1` and go to DELAY.
- DELAY: if `cnt==0`, pulse and go to the post-pulse state; else decrement `cnt`. Excite and relax conditions are ignored.
- Post-pulse state:
  - if `holdoff_i==0`: WAIT_RELAX.
  - else: latch `cnt = holdoff_i - 1` and go to HOLDOFF.
- HOLDOFF: if `cnt==0`, go to WAIT_RELAX; else decrement. Thresholds are ignored.
- Because every path returns through WAIT_RELAX, each trigger requires a fresh relax-then-excite sequence.
- `delay_i` and `holdoff_i` are sampled only at state entry. Changes while counting have no effect until the next entry.
- `enable_i` low: next state is WAIT_RELAX, `cnt` is cleared, no pulse, and any pending delayed trigger is discarded. Re-enabling starts in WAIT_RELAX, so a signal already above excite does not trigger.
- `trig_count_o` increments on every pulse and wraps from 0xFFFFFFFF to 0. `count_clr_i` sets it to 0; `count_clr_i` together with a pulse gives 1.
- `trig_age_o`:
  - increments every cycle and saturates at 0xFFFFFFFF;
  - loads 0 on the cycle the pulse is emitted, so it reads 0 while `trig_o`=1;
  - is unaffected by `enable_i`;
  - resets to 0xFFFFFFFF, meaning "never triggered".

## Timing
- Reset values: `trig_o`=0, `armed_o`=0, `trig_count_o`=0, `trig_age_o`=0xFFFFFFFF, `s_q`=0, `cnt`=0, state WAIT_RELAX. Reset asserted mid-DELAY or mid-HOLDOFF aborts immediately, with no pulse.
- Latency:
  - A sample present before edge k is captured at k.
  - If the FSM is ARMED and the excite condition holds, `trig_o` is high for exactly the cycle after edge k+1+D, where D = `delay_i`.
  - This gives 2+D cycles from input to pulse.
- `trig_o` is registered and never high for two consecutive cycles.
- Minimum pulse spacing: 1 (pulse) + H (HOLDOFF) + 1 (WAIT_RELAX) + 1 (ARMED) cycles, with H = `holdoff_i`.
- `armed_o` is registered and equals (state==ARMED).
- A relax and excite condition in the same cycle cannot occur, because the thresholds differ.
- Threshold writes take effect on the next comparison cycle.

## Test plan
- Rising mode, basic:
  - Stimulus: excite=1000, relax=200, delay=0, holdoff=0. Sample 0 for 5 cycles, then 1500.
  - Response: one pulse 2 cycles after 1500 appears; `trig_count_o`=1; `trig_age_o`=0 during the pulse, then 1, 2, …
  - Holding 1500 produces no further pulses.
- Hysteresis:
  - Stimulus: same settings; sample sequence 1500, 500, 1500 (500 is not ≤ 200).
  - Response: no second pulse.
  - Follow-up: 100, then 1500 gives a second pulse; count=2.
- Falling mode with delay:
  - Stimulus: excite=-800, relax=-100, delay=10. Sample 0, then -900.
  - Response: pulse exactly 12 cycles after -900 is applied.
- Holdoff:
  - Stimulus: holdoff=50. Toggle the sample between 0 and 1500 every 4 cycles.
  - Response: pulse spacing is at least 53 cycles, and pulses align to the first excite after holdoff expiry plus relaxation.
- Enable and clear:
  - Stimulus: `enable_i` dropped mid-DELAY (delay=100).
  - Response: no pulse; after re-enable with the sample held at 1500, no pulse until the sample relaxes.
  - Stimulus: `count_clr_i` coincident with a pulse.
  - Response: count reads 1.
- Degenerate and saturation:
  - Stimulus: excite==relax=300 with any input.
  - Response: `trig_o` never asserts.
  - Check: from reset with no triggers, `trig_age_o` stays 0xFFFFFFFF.
  - Stimulus: force the count to 0xFFFFFFFF, then one pulse.
  - Response: count wraps to 0.
